// File: rtl/key_loader_pkg.sv
// Shared types and constants for the serial key loader.
// Also provides a bit-serial CRC-8 step function for reference models.
package key_loader_pkg;

  localparam int         KEY_W    = 32;
  localparam int         CRC_W    = 8;
  localparam logic [7:0] CRC_POLY = 8'h07;
  localparam int         MAX_FAIL = 3;
  localparam int         CNT_W    = 6;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_KEY,
    SHIFT_CRC,
    CHECK,
    VALID,
    FAIL,
    LOCKOUT
  } state_t;

  // One MSB-first CRC step: init 0x00, no reflection, no final XOR.
  function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    return {crc[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/key_crc8.sv
// Bit-serial CRC-8 accumulator with synchronous clear and enable.
module key_crc8
  import key_loader_pkg::*;
#(
  parameter logic [7:0] POLY = CRC_POLY
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [7:0] crc
);

  logic [7:0] crc_q;
  logic       fb;

  assign fb = crc_q[7] ^ din;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= '0;
    end else if (clr) begin
      crc_q <= '0;
    end else if (en) begin
      crc_q <= {crc_q[6:0], 1'b0} ^ ({8{fb}} & POLY);
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/key_loader.sv
// Receives a serial key + CRC-8 frame, verifies it and drives the unlock key.
// Repeated CRC failures lock the unit until reset.
module key_loader
  import key_loader_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_start,
  input  logic             ld_bit_valid,
  input  logic             ld_bit,
  output logic             ld_busy,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             key_err,
  output logic [1:0]       fail_cnt,
  output logic             lockout
);

  localparam logic [CNT_W-1:0] KEY_LAST   = CNT_W'(KEY_W - 1);
  localparam logic [CNT_W-1:0] CRC_LAST   = CNT_W'(CRC_W - 1);
  localparam logic [1:0]       MAX_FAIL_C = 2'(MAX_FAIL);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [KEY_W-1:0] key_sh_q;
  logic [CRC_W-1:0] cmp_q;
  logic             cmp_full_q;
  logic [KEY_W-1:0] key_out_q;
  logic             key_valid_q;
  logic             key_err_q;
  logic [1:0]       fail_cnt_q;
  logic             lockout_q;

  logic             start_ok;
  logic             crc_en;
  logic [7:0]       crc_val;

  assign start_ok = ld_start && (state_q != LOCKOUT);
  assign crc_en   = (state_q == SHIFT_KEY) && ld_bit_valid && !ld_start;

  key_crc8 #(.POLY(CRC_POLY)) u_crc (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (start_ok),
    .en   (crc_en),
    .din  (ld_bit),
    .crc  (crc_val)
  );

  // NOTE: the shift and compare registers are reset too, so no stale key bits survive a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      key_sh_q    <= '0;
      cmp_q       <= '0;
      cmp_full_q  <= 1'b0;
      key_out_q   <= '0;
      key_valid_q <= 1'b0;
      key_err_q   <= 1'b0;
      fail_cnt_q  <= '0;
      lockout_q   <= 1'b0;
    end else if (start_ok) begin
      // Abort whatever is in flight; an aborted frame never counts as a failure.
      state_q     <= SHIFT_KEY;
      cnt_q       <= '0;
      key_sh_q    <= '0;
      cmp_q       <= '0;
      cmp_full_q  <= 1'b0;
      key_out_q   <= '0;
      key_valid_q <= 1'b0;
      key_err_q   <= 1'b0;
    end else begin
      case (state_q)
        SHIFT_KEY: begin
          if (ld_bit_valid) begin
            key_sh_q <= {ld_bit, key_sh_q[KEY_W-1:1]};
            if (cnt_q == KEY_LAST) begin
              cnt_q   <= '0;
              state_q <= SHIFT_CRC;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        SHIFT_CRC: begin
          // The compare register settles one cycle before CHECK uses it.
          if (cmp_full_q) begin
            cmp_full_q <= 1'b0;
            state_q    <= CHECK;
          end else if (ld_bit_valid) begin
            cmp_q <= {cmp_q[CRC_W-2:0], ld_bit};
            if (cnt_q == CRC_LAST) begin
              cnt_q      <= '0;
              cmp_full_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        CHECK: begin
          if (crc_val == cmp_q) begin
            key_out_q   <= key_sh_q;
            key_valid_q <= 1'b1;
            fail_cnt_q  <= '0;
            state_q     <= VALID;
          end else begin
            key_err_q <= 1'b1;
            if (fail_cnt_q == MAX_FAIL_C - 2'd1) begin
              fail_cnt_q <= MAX_FAIL_C;
              lockout_q  <= 1'b1;
              state_q    <= LOCKOUT;
            end else begin
              fail_cnt_q <= fail_cnt_q + 2'd1;
              state_q    <= FAIL;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign ld_busy   = (state_q == SHIFT_KEY) || (state_q == SHIFT_CRC) || (state_q == CHECK);
  assign key_out   = key_out_q;
  assign key_valid = key_valid_q;
  assign key_err   = key_err_q;
  assign fail_cnt  = fail_cnt_q;
  assign lockout   = lockout_q;

endmodule

// File: tb/tb_key_loader.sv
// Directed self-checking bench for key_loader: good/bad frames, abort, lockout, async reset.
module tb_key_loader;
  import key_loader_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        ld_start;
  logic        ld_bit_valid;
  logic        ld_bit;
  logic        ld_busy;
  logic [31:0] key_out;
  logic        key_valid;
  logic        key_err;
  logic [1:0]  fail_cnt;
  logic        lockout;

  int errors = 0;
  int checks = 0;

  key_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ld_start    (ld_start),
    .ld_bit_valid(ld_bit_valid),
    .ld_bit      (ld_bit),
    .ld_busy     (ld_busy),
    .key_out     (key_out),
    .key_valid   (key_valid),
    .key_err     (key_err),
    .fail_cnt    (fail_cnt),
    .lockout     (lockout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] model_crc(input logic [31:0] k);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < 32; i++) c = crc8_next(c, k[i]);
    return c;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start(input bit with_bit);
    ld_start     = 1'b1;
    ld_bit_valid = with_bit;
    ld_bit       = with_bit;
    step(1);
    ld_start     = 1'b0;
    ld_bit_valid = 1'b0;
    ld_bit       = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    ld_bit_valid = 1'b1;
    ld_bit       = b;
    step(1);
    ld_bit_valid = 1'b0;
    ld_bit       = 1'b0;
  endtask

  task automatic send_body(input logic [31:0] key, input logic [7:0] crc, input bit gaps);
    for (int i = 0; i < 32; i++) begin
      if (gaps) step($urandom_range(0, 2));
      send_bit(key[i]);
    end
    for (int i = 7; i >= 0; i--) begin
      if (gaps) step($urandom_range(0, 2));
      send_bit(crc[i]);
    end
  endtask

  task automatic send_frame(input logic [31:0] key, input logic [7:0] crc, input bit gaps);
    start(1'b0);
    send_body(key, crc, gaps);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ld_start = 1'b0; ld_bit_valid = 1'b0; ld_bit = 1'b0;
    step(2);
    checks++; if ({ld_busy, key_out, key_valid, key_err, fail_cnt, lockout} !== 38'd0) begin
      $display("FAIL reset_outputs: got busy=%b key=%h v=%b e=%b fc=%0d lo=%b, want all 0",
               ld_busy, key_out, key_valid, key_err, fail_cnt, lockout); errors++; end
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    send_bit(1'b1);
    checks++; if (ld_busy !== 1'b0) begin
      $display("FAIL idle_ignores_bits: busy=%b want 0", ld_busy); errors++; end
  endtask

  // T1: all-zero key and CRC, key_valid exactly two cycles after the last bit.
  task automatic test_zero_key();
    send_frame(32'h0, 8'h00, 1'b0);
    checks++; if (key_valid !== 1'b0 || ld_busy !== 1'b1) begin
      $display("FAIL t1_edge_n: valid=%b busy=%b want 0/1", key_valid, ld_busy); errors++; end
    step(1);
    checks++; if (key_valid !== 1'b0 || ld_busy !== 1'b1) begin
      $display("FAIL t1_check_cycle: valid=%b busy=%b want 0/1", key_valid, ld_busy); errors++; end
    step(1);
    checks++; if (key_valid !== 1'b1 || key_out !== 32'h0 || fail_cnt !== 2'd0 || ld_busy !== 1'b0) begin
      $display("FAIL t1_result: valid=%b key=%h fc=%0d busy=%b want 1/00000000/0/0",
               key_valid, key_out, fail_cnt, ld_busy); errors++; end
  endtask

  // T2: 0xDEADBEEF with random valid gaps.
  task automatic test_gapped_key();
    send_frame(32'hDEADBEEF, model_crc(32'hDEADBEEF), 1'b1);
    step(2);
    checks++; if (key_valid !== 1'b1 || key_out !== 32'hDEADBEEF || key_err !== 1'b0) begin
      $display("FAIL t2_result: valid=%b key=%h err=%b want 1/deadbeef/0", key_valid, key_out, key_err); errors++; end
    send_bit(1'b0);
    checks++; if (key_out !== 32'hDEADBEEF || ld_busy !== 1'b0) begin
      $display("FAIL t2_valid_ignores_bits: key=%h busy=%b want deadbeef/0", key_out, ld_busy); errors++; end
  endtask

  // T5: abort at key bit 17, restart (with a same-cycle valid bit that must be ignored).
  task automatic test_abort();
    start(1'b0);
    checks++; if (key_out !== 32'h0 || key_valid !== 1'b0 || ld_busy !== 1'b1) begin
      $display("FAIL t5_start_clears: key=%h valid=%b busy=%b want 0/0/1", key_out, key_valid, ld_busy); errors++; end
    for (int i = 0; i < 17; i++) send_bit(1'b1);
    checks++; if (key_out !== 32'h0 || key_valid !== 1'b0) begin
      $display("FAIL t5_no_partial_key: key=%h valid=%b want 0/0", key_out, key_valid); errors++; end
    start(1'b1);
    send_body(32'h12345678, model_crc(32'h12345678), 1'b0);
    checks++; if (key_out !== 32'h0) begin
      $display("FAIL t5_before_check: key=%h want 0", key_out); errors++; end
    step(2);
    checks++; if (key_valid !== 1'b1 || key_out !== 32'h12345678 || fail_cnt !== 2'd0 || key_err !== 1'b0) begin
      $display("FAIL t5_result: valid=%b key=%h fc=%0d err=%b want 1/12345678/0/0",
               key_valid, key_out, fail_cnt, key_err); errors++; end
  endtask

  // T3: zero key with CRC 0x01.
  task automatic test_bad_crc();
    send_frame(32'h0, 8'h01, 1'b0);
    step(2);
    checks++; if (key_err !== 1'b1 || fail_cnt !== 2'd1 || key_valid !== 1'b0 || key_out !== 32'h0 || lockout !== 1'b0) begin
      $display("FAIL t3_result: err=%b fc=%0d valid=%b key=%h lo=%b want 1/1/0/0/0",
               key_err, fail_cnt, key_valid, key_out, lockout); errors++; end
  endtask

  // T4: continuing from T3, two more bad frames reach lockout; later frames are ignored.
  task automatic test_lockout();
    start(1'b0);
    checks++; if (key_err !== 1'b0 || fail_cnt !== 2'd1) begin
      $display("FAIL t4_start_clears_err: err=%b fc=%0d want 0/1", key_err, fail_cnt); errors++; end
    send_body(32'hCAFEF00D, model_crc(32'hCAFEF00D) ^ 8'h80, 1'b0);
    step(2);
    checks++; if (fail_cnt !== 2'd2 || lockout !== 1'b0 || key_err !== 1'b1) begin
      $display("FAIL t4_second_fail: fc=%0d lo=%b err=%b want 2/0/1", fail_cnt, lockout, key_err); errors++; end
    send_frame(32'h0, 8'hFF, 1'b0);
    step(1);
    checks++; if (lockout !== 1'b0 || ld_busy !== 1'b1) begin
      $display("FAIL t4_pre_lock: lo=%b busy=%b want 0/1", lockout, ld_busy); errors++; end
    step(1);
    checks++; if (lockout !== 1'b1 || fail_cnt !== 2'd3 || key_err !== 1'b1 || ld_busy !== 1'b0) begin
      $display("FAIL t4_lockout: lo=%b fc=%0d err=%b busy=%b want 1/3/1/0",
               lockout, fail_cnt, key_err, ld_busy); errors++; end
    send_frame(32'h12345678, model_crc(32'h12345678), 1'b0);
    step(3);
    checks++; if (lockout !== 1'b1 || key_valid !== 1'b0 || key_out !== 32'h0 || ld_busy !== 1'b0 || fail_cnt !== 2'd3) begin
      $display("FAIL t4_ignored: lo=%b valid=%b key=%h busy=%b fc=%0d want 1/0/0/0/3",
               lockout, key_valid, key_out, ld_busy, fail_cnt); errors++; end
  endtask

  // T6: asynchronous reset in the middle of SHIFT_CRC.
  task automatic test_async_reset();
    do_reset();
    checks++; if (lockout !== 1'b0 || fail_cnt !== 2'd0) begin
      $display("FAIL t6_reset_clears_lockout: lo=%b fc=%0d want 0/0", lockout, fail_cnt); errors++; end
    send_frame(32'h0, 8'h01, 1'b0);
    step(2);
    start(1'b0);
    for (int i = 0; i < 32; i++) send_bit(i[0]);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    checks++; if (ld_busy !== 1'b1 || fail_cnt !== 2'd1) begin
      $display("FAIL t6_pre_reset: busy=%b fc=%0d want 1/1", ld_busy, fail_cnt); errors++; end
    #3 rst_n = 1'b0;
    #1;
    checks++; if ({ld_busy, key_out, key_valid, key_err, fail_cnt, lockout} !== 38'd0) begin
      $display("FAIL t6_async_clear: busy=%b key=%h v=%b e=%b fc=%0d lo=%b want all 0",
               ld_busy, key_out, key_valid, key_err, fail_cnt, lockout); errors++; end
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    checks++; if (ld_busy !== 1'b0 || key_valid !== 1'b0) begin
      $display("FAIL t6_idle_after_release: busy=%b valid=%b want 0/0", ld_busy, key_valid); errors++; end
  endtask

  initial begin
    test_reset();
    test_zero_key();
    test_gapped_key();
    test_abort();
    test_bad_crc();
    test_lockout();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
